// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: fetch FSM states, datapath widths and the canonical NOP.
package riscv_pipe_pkg;

   localparam int ADDR_W = 64;
   localparam int INST_W = 32;

   localparam logic [31:0] NOP_INST = 32'h00000013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   // Any state other than IDLE has a memory transaction outstanding.
   function automatic logic fetch_busy(input fetch_state_t s);
      return s != IDLE;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc, instr} FIFO with synchronous clear; head outputs read as zero when empty.
module fetch_fifo #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 64,
   parameter int INST_W = 32,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic [INST_W-1:0] push_instr,
   input  logic              pop,
   input  logic              clear,
   output logic [ADDR_W-1:0] head_pc,
   output logic [INST_W-1:0] head_instr,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] pc_mem    [DEPTH];
   logic [INST_W-1:0] instr_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push & ~full & ~clear;
   assign do_pop  = pop & ~empty & ~clear;

   // Storage is left unreset; the empty mask keeps stale words off the outputs.
   always_ff @(posedge clk) begin
      if (do_push) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_pc    = empty ? '0 : pc_mem[rd_ptr];
   assign head_instr = empty ? '0 : instr_mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: one imem req/ack per PC, results queued toward decode,
// taken-branch flush discards queued and in-flight work.
module if_fetch_queue #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = riscv_pipe_pkg::ADDR_W,
   parameter int INST_W = riscv_pipe_pkg::INST_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              PC_write,
   input  logic              flush,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_instr,
   input  logic              id_ready
);

   import riscv_pipe_pkg::*;

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              issue, push, pop;
   logic              full, empty;
   logic [CNT_W-1:0]  count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!flush && !full) state_d = WAIT;
         WAIT:    if (imem_ack)        state_d = IDLE;
                  else if (flush)      state_d = DROP;
         DROP:    if (imem_ack)        state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Issue is gated on a free slot, so the push that ends WAIT always has room.
   always_comb begin
      issue    = (state_q == IDLE) & ~flush & ~full;
      push     = (state_q == WAIT) & imem_ack & ~flush;
      imem_req = fetch_busy(state_q);
      PC_write = rst | flush | push;
   end

   // Address only moves on issue, so it is stable for the whole req/ack window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        addr_q <= '0;
      else if (issue) addr_q <= pc_in;
   end

   assign imem_addr = addr_q;
   assign id_valid  = ~empty;
   assign pop       = id_valid & id_ready;

   fetch_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .INST_W (INST_W),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_pc    (addr_q),
      .push_instr (imem_rdata),
      .pop        (pop),
      .clear      (flush),
      .head_pc    (id_pc),
      .head_instr (id_instr),
      .count      (count),
      .empty      (empty),
      .full       (full)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> !full);
   a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a per-cycle vector table for the streaming/backpressure
// case plus hand sequences for wait states, flush and mid-transaction reset.
module tb_if_fetch_queue;
   import riscv_pipe_pkg::*;

   localparam int AW = 64;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          id_ready = 1'b0;
   logic          imem_ack = 1'b0;
   logic [AW-1:0] pc_in = '0;
   logic [IW-1:0] imem_rdata = '0;
   logic          PC_write, imem_req, id_valid;
   logic [AW-1:0] imem_addr, id_pc;
   logic [IW-1:0] id_instr;

   int            checks = 0;
   int            errors = 0;
   int            lat = 0;
   int            wcnt = 0;
   logic [AW-1:0] target = '0;

   if_fetch_queue dut (
      .clk        (clk),
      .rst        (rst),
      .pc_in      (pc_in),
      .PC_write   (PC_write),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_pc      (id_pc),
      .id_instr   (id_instr),
      .id_ready   (id_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
      return 32'h00500093 + a[31:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Cross one rising edge; model the PC stage and a memory that acks after `lat` wait cycles.
   task automatic step();
      logic req_b, ack_b, pw_b, fl_b, rst_b;
      req_b = imem_req; ack_b = imem_ack; pw_b = PC_write; fl_b = flush; rst_b = rst;
      @(negedge clk);
      wcnt = (req_b && !ack_b) ? wcnt + 1 : 0;
      if (rst_b)     pc_in = '0;
      else if (fl_b) pc_in = target;
      else if (pw_b) pc_in = pc_in + 64'd4;
      #1;
      imem_ack   = imem_req && (wcnt >= lat);
      imem_rdata = imem_ack ? inst_of(imem_addr) : '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; id_ready = 1'b0; lat = 0;
      imem_ack = 1'b0; imem_rdata = '0;
      step(); step();
      #1;
      chk("rst.pc_write", PC_write, 1'b1);
      chk("rst.req",      imem_req, 1'b0);
      chk("rst.addr",     imem_addr, '0);
      chk("rst.valid",    id_valid, 1'b0);
      chk("rst.id_pc",    id_pc, '0);
      chk("rst.id_instr", id_instr, '0);
      chk("rst.count",    dut.count, '0);
      chk("rst.state",    64'(dut.state_q), 64'(IDLE));
      rst = 1'b0;
   endtask

   typedef struct {
      logic          rdy;
      logic          pw;
      logic          req;
      logic [AW-1:0] addr;
      logic          vld;
      logic [AW-1:0] pc;
      logic [IW-1:0] ins;
   } vec_t;

   vec_t tbl [11];

   function automatic vec_t mk(input logic rdy, input logic pw, input logic req,
                               input logic [AW-1:0] addr, input logic vld,
                               input logic [AW-1:0] pc, input logic [IW-1:0] ins);
      vec_t v;
      v.rdy = rdy; v.pw = pw; v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.ins = ins;
      return v;
   endfunction

   initial begin
      // Zero-wait memory, PC stream from 0; decode stalls from cycle 2 through cycle 5.
      tbl[0]  = mk(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
      tbl[1]  = mk(1'b1, 1'b1, 1'b1, 64'h0, 1'b0, 64'h0, 32'h0);
      tbl[2]  = mk(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 32'h00500093);
      tbl[3]  = mk(1'b0, 1'b1, 1'b1, 64'h4, 1'b1, 64'h0, 32'h00500093);
      tbl[4]  = mk(1'b0, 1'b0, 1'b0, 64'h4, 1'b1, 64'h0, 32'h00500093);
      tbl[5]  = mk(1'b0, 1'b0, 1'b0, 64'h4, 1'b1, 64'h0, 32'h00500093);
      tbl[6]  = mk(1'b1, 1'b0, 1'b0, 64'h4, 1'b1, 64'h0, 32'h00500093);
      tbl[7]  = mk(1'b1, 1'b0, 1'b0, 64'h4, 1'b1, 64'h4, 32'h00500097);
      tbl[8]  = mk(1'b1, 1'b1, 1'b1, 64'h8, 1'b0, 64'h0, 32'h0);
      tbl[9]  = mk(1'b1, 1'b0, 1'b0, 64'h8, 1'b1, 64'h8, 32'h0050009B);
      tbl[10] = mk(1'b1, 1'b1, 1'b1, 64'hC, 1'b0, 64'h0, 32'h0);

      do_reset();
      for (int i = 0; i < 11; i++) begin
         string nm;
         if (i > 0) step();
         id_ready = tbl[i].rdy;
         #1;
         nm = $sformatf("vec%0d", i);
         chk({nm, ".pc_write"}, PC_write,  tbl[i].pw);
         chk({nm, ".req"},      imem_req,  tbl[i].req);
         chk({nm, ".addr"},     imem_addr, tbl[i].addr);
         chk({nm, ".valid"},    id_valid,  tbl[i].vld);
         chk({nm, ".id_pc"},    id_pc,     tbl[i].pc);
         chk({nm, ".id_instr"}, id_instr,  tbl[i].ins);
      end

      // Three-cycle ack latency: request held with a stable address, one push.
      do_reset();
      lat = 2;
      pc_in = 64'h100;
      #1;
      chk("lat.c0.req", imem_req, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         step(); #1;
         chk($sformatf("lat.c%0d.req", c),  imem_req, 1'b1);
         chk($sformatf("lat.c%0d.addr", c), imem_addr, 64'h100);
         chk($sformatf("lat.c%0d.pw", c),   PC_write, (c == 3));
      end
      step(); #1;
      chk("lat.c4.valid", id_valid, 1'b1);
      chk("lat.c4.id_pc", id_pc, 64'h100);
      chk("lat.c4.instr", id_instr, 32'h00500193);
      chk("lat.c4.req",   imem_req, 1'b0);
      step(); #1;
      chk("lat.c5.count", dut.count, 2'd1);
      chk("lat.c5.addr",  imem_addr, 64'h104);

      // Flush while waiting for ack with one entry queued.
      do_reset();
      #1;
      step(); #1;
      step(); #1;
      chk("fw.c2.count", dut.count, 2'd1);
      lat = 5;
      step();
      flush = 1'b1; target = 64'h200;
      #1;
      chk("fw.c3.pw",    PC_write, 1'b1);
      chk("fw.c3.req",   imem_req, 1'b1);
      chk("fw.c3.valid", id_valid, 1'b1);
      step();
      flush = 1'b0;
      #1;
      chk("fw.c4.state", 64'(dut.state_q), 64'(DROP));
      chk("fw.c4.req",   imem_req, 1'b1);
      chk("fw.c4.addr",  imem_addr, 64'h4);
      chk("fw.c4.valid", id_valid, 1'b0);
      chk("fw.c4.pw",    PC_write, 1'b0);
      lat = 2;
      step(); #1;
      chk("fw.c5.ack",   imem_ack, 1'b1);
      chk("fw.c5.pw",    PC_write, 1'b0);
      chk("fw.c5.addr",  imem_addr, 64'h4);
      step(); #1;
      chk("fw.c6.state", 64'(dut.state_q), 64'(IDLE));
      chk("fw.c6.valid", id_valid, 1'b0);
      chk("fw.c6.count", dut.count, 2'd0);
      chk("fw.c6.req",   imem_req, 1'b0);
      step(); #1;
      chk("fw.c7.req",   imem_req, 1'b1);
      chk("fw.c7.addr",  imem_addr, 64'h200);

      // Flush coincident with ack and a pop.
      do_reset();
      #1;
      step(); #1;
      step(); #1;
      step();
      id_ready = 1'b1; flush = 1'b1; target = 64'h300;
      #1;
      chk("fa.c3.ack",   imem_ack, 1'b1);
      chk("fa.c3.pw",    PC_write, 1'b1);
      chk("fa.c3.valid", id_valid, 1'b1);
      step();
      flush = 1'b0;
      #1;
      chk("fa.c4.valid", id_valid, 1'b0);
      chk("fa.c4.count", dut.count, 2'd0);
      chk("fa.c4.state", 64'(dut.state_q), 64'(IDLE));
      chk("fa.c4.req",   imem_req, 1'b0);
      chk("fa.c4.pw",    PC_write, 1'b0);
      step(); #1;
      chk("fa.c5.req",   imem_req, 1'b1);
      chk("fa.c5.addr",  imem_addr, 64'h300);

      // Reset asserted mid-transaction with a queued entry.
      do_reset();
      #1;
      step(); #1;
      step(); #1;
      lat = 5;
      step(); #1;
      chk("rw.pre.state", 64'(dut.state_q), 64'(WAIT));
      chk("rw.pre.count", dut.count, 2'd1);
      rst = 1'b1;
      #1;
      chk("rw.req",   imem_req, 1'b0);
      chk("rw.valid", id_valid, 1'b0);
      chk("rw.count", dut.count, 2'd0);
      chk("rw.pw",    PC_write, 1'b1);
      chk("rw.addr",  imem_addr, '0);
      step();
      rst = 1'b0;
      #1;
      step(); #1;
      chk("rw.restart.req",  imem_req, 1'b1);
      chk("rw.restart.addr", imem_addr, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
